// File: rtl/cu_ex_result_buffer_if.sv
// EX result bus plus MEM/WB valid/ready head port for cu_ex_result_buffer.
// The slave modport is the buffer; the master modport is the EX / MEM-WB side.
interface cu_ex_result_buffer_if #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5
);
    logic [DATA_W-1:0] result_data;
    logic              result_ready;
    logic              overflow_flag;
    logic              zero_flag;
    logic              condition_met_flag;
    logic              error_flag;
    logic [RD_W-1:0]   rd_addr;
    logic              reg_write_en;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [RD_W-1:0]   out_rd_addr;
    logic              out_reg_write_en;
    logic [3:0]        out_flags;

    modport slave (
        input  result_data, result_ready, overflow_flag, zero_flag,
        input  condition_met_flag, error_flag, rd_addr, reg_write_en,
        input  out_ready,
        output out_valid, out_data, out_rd_addr, out_reg_write_en, out_flags
    );

    modport master (
        output result_data, result_ready, overflow_flag, zero_flag,
        output condition_met_flag, error_flag, rd_addr, reg_write_en,
        output out_ready,
        input  out_valid, out_data, out_rd_addr, out_reg_write_en, out_flags
    );
endinterface

// File: rtl/cu_ex_result_buffer.sv
// In-order FWFT result FIFO between the EX control unit and MEM/WB.
// Ports: soc_clk, EX_reset (async, active-high), flush, bus (result in /
// head out), EX_stall_req back-pressure, count occupancy, drop_err sticky.
module cu_ex_result_buffer #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5,
    parameter int DEPTH  = 2
) (
    input  logic                     soc_clk,
    input  logic                     EX_reset,
    input  logic                     flush,
    cu_ex_result_buffer_if.slave     bus,
    output logic                     EX_stall_req,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop_err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = DATA_W + RD_W + 5;

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             rr_q;
    logic             drop_q, drop_d;

    logic             push_req, push_acc, pop, full;
    logic [ENT_W-1:0] wr_ent, head;

    // Rising edge of result_ready: a held level captures only once.
    assign push_req = bus.result_ready & ~rr_q;
    assign full     = (count_q == CNT_W'(DEPTH));
    assign pop      = bus.out_valid & bus.out_ready;
    // When full, a same-edge pop frees the slot being written.
    assign push_acc = push_req & (~full | pop);

    assign wr_ent = {bus.result_data, bus.rd_addr, bus.reg_write_en,
                     bus.error_flag, bus.condition_met_flag,
                     bus.zero_flag, bus.overflow_flag};

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        drop_d   = drop_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_acc)
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push_acc && !pop)
                count_d = count_q + CNT_W'(1);
            else if (pop && !push_acc)
                count_d = count_q - CNT_W'(1);
            if (push_req && !push_acc)
                drop_d = 1'b1;
        end
    end

    always_ff @(posedge soc_clk or posedge EX_reset) begin
        if (EX_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rr_q     <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rr_q     <= bus.result_ready;
            drop_q   <= drop_d;
        end
    end

    // Storage needs no reset: every output is masked while count is 0.
    always_ff @(posedge soc_clk) begin
        if (push_acc && !flush)
            mem_q[wr_ptr_q] <= wr_ent;
    end

    assign head = mem_q[rd_ptr_q];

    always_comb begin
        bus.out_valid        = 1'b0;
        bus.out_data         = '0;
        bus.out_rd_addr      = '0;
        bus.out_reg_write_en = 1'b0;
        bus.out_flags        = '0;
        if (count_q != '0) begin
            bus.out_valid        = 1'b1;
            bus.out_data         = head[ENT_W-1 -: DATA_W];
            bus.out_rd_addr      = head[RD_W+4 : 5];
            // An errored result never writes the register file.
            bus.out_reg_write_en = head[4] & ~head[3];
            bus.out_flags        = head[3:0];
        end
    end

    // One entry of headroom for a result already in flight in EX.
    assign EX_stall_req = (count_q >= CNT_W'(DEPTH - 1));
    assign count        = count_q;
    assign drop_err     = drop_q;
endmodule

// File: doc/cu_ex_result_buffer.md
Name: cu_ex_result_buffer

Overview:
- Sits directly downstream of the EX stage control unit. Captures each EX result (data, four ALU flags, destination register) once per result_ready pulse.
- Holds results in a small in-order FIFO and presents them to the MEM/WB stage over a valid/ready handshake.
- Raises a stall request back to EX when nearly full, so EX results are not lost while the downstream stage is busy.

Parameters:
- DATA_W, 32, width of result data
- RD_W, 5, width of destination register address
- DEPTH, 2, FIFO entries; must be a power of 2 and ≥2

Ports:
- soc_clk  in  1  system clock; all state updates on rising edge
- EX_reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous discard of all buffered entries (branch/exception)
- result_data  in  DATA_W  EX result
- result_ready  in  1  EX result valid; level may be held ≥1 cycle
- overflow_flag  in  1  EX overflow
- zero_flag  in  1  EX zero
- condition_met_flag  in  1  EX branch condition
- error_flag  in  1  EX/ALU error
- rd_addr  in  RD_W  destination register of the instruction in EX
- reg_write_en  in  1  instruction writes rd
- out_valid  out  1  head entry available
- out_ready  in  1  downstream accepts head entry
- out_data  out  DATA_W  head result
- out_rd_addr  out  RD_W  head destination
- out_reg_write_en  out  1  head write enable, gated by error
- out_flags  out  4  head flags {error, condition_met, zero, overflow}
- EX_stall_req  out  1  back-pressure request to EX
- count  out  $clog2(DEPTH)+1  occupancy
- drop_err  out  1  sticky: a result was lost because the FIFO was full

Behaviour:
- Reset (EX_reset high, async): count=0; rd/wr pointers=0; result_ready_q=0; drop_err=0. Outputs are then out_valid=0, out_data=0, out_rd_addr=0, out_reg_write_en=0, out_flags=0, EX_stall_req=0.
- Capture rule: push_req = result_ready & ~result_ready_q. result_ready_q is a registered copy of result_ready. A level held for several cycles produces exactly one push.
- Entry contents: {result_data, rd_addr, reg_write_en, error_flag, condition_met_flag, zero_flag, overflow_flag}, sampled on the same edge as the push.
- Pop: pop = out_valid & out_ready.
- Head presentation: first-word fall-through. out_* are driven from the head entry while count≠0, and are forced to 0 when count=0.
- out_reg_write_en = stored reg_write_en & ~stored error. An errored result never writes the register file.
- Latency: a push on edge N gives out_valid=1 after edge N, so the consumer can pop on edge N+1.
- Occupancy arithmetic: count_next = count + (push accepted) − pop.
  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH with no extra logic.
- Full (count=DEPTH):
  - With pop on the same edge: the push is accepted and count is unchanged.
  - Without pop: the push is dropped, drop_err set to 1 (cleared only by EX_reset), and FIFO contents are unchanged.
- Empty (count=0): pop is impossible because out_valid=0. A push and out_ready on the same edge does not bypass; the entry appears the following cycle.
- EX_stall_req = (count ≥ DEPTH−1), combinational from count. It asserts one entry early so that an in-flight EX result still has room.
- flush (synchronous, priority over push/pop):
  - count, pointers → 0, so out_valid=0 after the edge.
  - A push_req on the same edge is discarded and does not set drop_err.
  - result_ready_q still updates, so a held result_ready is not recaptured after the flush.
- Reset mid-operation: all entries are lost immediately. out_valid drops asynchronously.
- No combinational path from out_ready to any output except through registered state. EX_stall_req depends only on count.

Test Plan:
- Single capture: result_ready high 1 cycle with data=0x0000_002A, rd=5, wr_en=1 → out_valid next cycle, out_data=0x2A, out_rd_addr=5, out_reg_write_en=1; with out_ready=1, count returns to 0 one edge later.
- Held level: result_ready high 3 cycles, data=0x1234 → exactly one entry, count=1.
- Fill and back-pressure, out_ready=0:
  - Two pulses, data 0x11 then 0x22 → EX_stall_req=1 from count=1; count=2.
  - Third pulse 0x33 → dropped, drop_err=1.
  - Then out_ready=1 → pops 0x11, 0x22 in order.
- Full with simultaneous push/pop: count=2, push 0x44 on the same edge as a pop of head 0x11 → count stays 2, the next heads are 0x22 then 0x44, drop_err stays 0.
- Error gating and flush:
  - Push with error_flag=1, wr_en=1 → out_flags=4'b1000, out_reg_write_en=0.
  - Assert flush alongside a new push → count=0, out_valid=0, no entry is added.
- Async reset: assert EX_reset between clock edges with count=2 → out_valid=0 and count=0 immediately, drop_err=0, and all outputs are 0 before the next edge.
